// File: rtl/useq_pkg.sv
// Shared definitions for the useq mailbox: error-flag layout and count-vector packing.
package useq_pkg;

    localparam int ERR_H2C_OVF  = 0;
    localparam int ERR_H2C_UDF  = 1;
    localparam int ERR_C2H_OVF  = 2;
    localparam int ERR_C2H_UDF  = 3;
    localparam int ERR_PER_CHAN = 4;

    // LSB of channel 'chan' inside a packed per-channel count vector of 'nw'-bit fields.
    function automatic int count_lsb(input int chan, input int nw);
        return chan * nw;
    endfunction

endpackage

// File: rtl/useq_mailbox_if.sv
// Host/core bus bundle for the useq mailbox; slave is the mailbox, master is the host/core side.
interface useq_mailbox_if #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int NUM_CHAN = 2
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int NW = AW + 1;

    logic                     h_wr;
    logic [CW-1:0]            h_wr_chan;
    logic [DATA_W-1:0]        h_wr_data;
    logic                     h_rd;
    logic [CW-1:0]            h_rd_chan;
    logic [DATA_W-1:0]        h_rd_data;
    logic                     h_rd_valid;
    logic                     c_wr;
    logic [CW-1:0]            c_wr_chan;
    logic [DATA_W-1:0]        c_wr_data;
    logic                     c_rd;
    logic [CW-1:0]            c_rd_chan;
    logic [DATA_W-1:0]        c_rd_data;
    logic                     c_rd_valid;
    logic [NUM_CHAN*NW-1:0]   h2c_count;
    logic [NUM_CHAN*NW-1:0]   c2h_count;
    logic [NUM_CHAN-1:0]      h2c_full;
    logic [NUM_CHAN-1:0]      h2c_empty;
    logic [NUM_CHAN-1:0]      c2h_full;
    logic [NUM_CHAN-1:0]      c2h_empty;
    logic [NUM_CHAN-1:0]      core_irq;
    logic [NUM_CHAN-1:0]      host_irq;
    logic [4*NUM_CHAN-1:0]    err;
    logic                     err_clr;

    modport slave (
        input  h_wr, h_wr_chan, h_wr_data, h_rd, h_rd_chan,
        input  c_wr, c_wr_chan, c_wr_data, c_rd, c_rd_chan, err_clr,
        output h_rd_data, h_rd_valid, c_rd_data, c_rd_valid,
        output h2c_count, c2h_count, h2c_full, h2c_empty, c2h_full, c2h_empty,
        output core_irq, host_irq, err
    );

    modport master (
        output h_wr, h_wr_chan, h_wr_data, h_rd, h_rd_chan,
        output c_wr, c_wr_chan, c_wr_data, c_rd, c_rd_chan, err_clr,
        input  h_rd_data, h_rd_valid, c_rd_data, c_rd_valid,
        input  h2c_count, c2h_count, h2c_full, h2c_empty, c2h_full, c2h_empty,
        input  core_irq, host_irq, err
    );

endinterface

// File: rtl/useq_mbox_fifo.sv
// Single-direction mailbox FIFO: head-of-queue peek, accept/error strobes and a
// registered pulse when the fill level rises through the threshold.
module useq_mbox_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int IRQ_THRESH = 1,
    localparam int AW        = $clog2(DEPTH),
    localparam int NW        = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    output logic [DATA_W-1:0] rd_head,
    output logic              rd_acc,
    output logic [NW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              udf,
    output logic              xing
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [NW-1:0]     count_q, count_d;
    logic              above_q, above_d;
    logic              xing_q, xing_d;
    logic              wr_acc_s;

    assign rd_head = mem_q[rptr_q];
    assign count   = count_q;
    assign xing    = xing_q;

    // Acceptance, error strobes and next-state for pointers, level and threshold tracking.
    always_comb begin
        full     = (count_q == NW'(DEPTH));
        empty    = (count_q == {NW{1'b0}});
        wr_acc_s = wr & ~full;
        rd_acc   = rd & ~empty;
        ovf      = wr & full;
        udf      = rd & empty;

        if (wr_acc_s) begin
            wptr_d = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_acc) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({wr_acc_s, rd_acc})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase

        // The pulse follows the registered level, so it lands one cycle after the count moves.
        above_d = (count_q >= NW'(IRQ_THRESH));
        xing_d  = above_d & ~above_q;
    end

    // Pointer, level and threshold state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {NW{1'b0}};
            above_q <= 1'b0;
            xing_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            above_q <= above_d;
            xing_q  <= xing_d;
        end
    end

    // Storage is deliberately not reset; a stale entry is unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc_s) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/useq_mailbox.sv
// Multi-channel host<->core mailbox: per-channel h2c/c2h FIFOs, channel decode,
// registered read ports and sticky per-channel error flags.
module useq_mailbox
    import useq_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int NUM_CHAN   = 2,
    parameter int IRQ_THRESH = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    useq_mailbox_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int NW = AW + 1;
    localparam int EW = ERR_PER_CHAN * NUM_CHAN;

    logic [DATA_W-1:0]   h2c_head_s [NUM_CHAN];
    logic [DATA_W-1:0]   c2h_head_s [NUM_CHAN];
    logic [NUM_CHAN-1:0] h2c_rd_acc_s, c2h_rd_acc_s;
    logic [NUM_CHAN-1:0] h2c_ovf_s, h2c_udf_s, c2h_ovf_s, c2h_udf_s;

    logic [DATA_W-1:0]   h_rd_data_q, h_rd_data_d;
    logic                h_rd_valid_q, h_rd_valid_d;
    logic [DATA_W-1:0]   c_rd_data_q, c_rd_data_d;
    logic                c_rd_valid_q, c_rd_valid_d;
    logic [EW-1:0]       err_q, err_d;

    // A select outside 0..NUM_CHAN-1 matches no channel, so the strobe vanishes silently.
    for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
        logic [NW-1:0] h2c_cnt_s, c2h_cnt_s;

        useq_mbox_fifo #(
            .DATA_W     (DATA_W),
            .DEPTH      (DEPTH),
            .IRQ_THRESH (IRQ_THRESH)
        ) u_h2c (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr      (bus.h_wr & (bus.h_wr_chan == CW'(k))),
            .wr_data (bus.h_wr_data),
            .rd      (bus.c_rd & (bus.c_rd_chan == CW'(k))),
            .rd_head (h2c_head_s[k]),
            .rd_acc  (h2c_rd_acc_s[k]),
            .count   (h2c_cnt_s),
            .full    (bus.h2c_full[k]),
            .empty   (bus.h2c_empty[k]),
            .ovf     (h2c_ovf_s[k]),
            .udf     (h2c_udf_s[k]),
            .xing    (bus.core_irq[k])
        );

        useq_mbox_fifo #(
            .DATA_W     (DATA_W),
            .DEPTH      (DEPTH),
            .IRQ_THRESH (IRQ_THRESH)
        ) u_c2h (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr      (bus.c_wr & (bus.c_wr_chan == CW'(k))),
            .wr_data (bus.c_wr_data),
            .rd      (bus.h_rd & (bus.h_rd_chan == CW'(k))),
            .rd_head (c2h_head_s[k]),
            .rd_acc  (c2h_rd_acc_s[k]),
            .count   (c2h_cnt_s),
            .full    (bus.c2h_full[k]),
            .empty   (bus.c2h_empty[k]),
            .ovf     (c2h_ovf_s[k]),
            .udf     (c2h_udf_s[k]),
            .xing    (bus.host_irq[k])
        );

        assign bus.h2c_count[count_lsb(k, NW) +: NW] = h2c_cnt_s;
        assign bus.c2h_count[count_lsb(k, NW) +: NW] = c2h_cnt_s;
    end

    assign bus.h_rd_data  = h_rd_data_q;
    assign bus.h_rd_valid = h_rd_valid_q;
    assign bus.c_rd_data  = c_rd_data_q;
    assign bus.c_rd_valid = c_rd_valid_q;
    assign bus.err        = err_q;

    // Read-port muxing and sticky error update; new errors win over a same-cycle clear.
    always_comb begin
        h_rd_data_d  = h_rd_data_q;
        h_rd_valid_d = 1'b0;
        c_rd_data_d  = c_rd_data_q;
        c_rd_valid_d = 1'b0;

        if (bus.err_clr) begin
            err_d = {EW{1'b0}};
        end else begin
            err_d = err_q;
        end

        for (int k = 0; k < NUM_CHAN; k++) begin
            h_rd_data_d  = c2h_rd_acc_s[k] ? c2h_head_s[k] : h_rd_data_d;
            h_rd_valid_d = h_rd_valid_d | c2h_rd_acc_s[k];
            c_rd_data_d  = h2c_rd_acc_s[k] ? h2c_head_s[k] : c_rd_data_d;
            c_rd_valid_d = c_rd_valid_d | h2c_rd_acc_s[k];

            err_d[ERR_PER_CHAN*k + ERR_H2C_OVF] = err_d[ERR_PER_CHAN*k + ERR_H2C_OVF] | h2c_ovf_s[k];
            err_d[ERR_PER_CHAN*k + ERR_H2C_UDF] = err_d[ERR_PER_CHAN*k + ERR_H2C_UDF] | h2c_udf_s[k];
            err_d[ERR_PER_CHAN*k + ERR_C2H_OVF] = err_d[ERR_PER_CHAN*k + ERR_C2H_OVF] | c2h_ovf_s[k];
            err_d[ERR_PER_CHAN*k + ERR_C2H_UDF] = err_d[ERR_PER_CHAN*k + ERR_C2H_UDF] | c2h_udf_s[k];
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_rd_data_q  <= {DATA_W{1'b0}};
            h_rd_valid_q <= 1'b0;
            c_rd_data_q  <= {DATA_W{1'b0}};
            c_rd_valid_q <= 1'b0;
            err_q        <= {EW{1'b0}};
        end else begin
            h_rd_data_q  <= h_rd_data_d;
            h_rd_valid_q <= h_rd_valid_d;
            c_rd_data_q  <= c_rd_data_d;
            c_rd_valid_q <= c_rd_valid_d;
            err_q        <= err_d;
        end
    end

endmodule
